// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, next-PC selection, and an instruction memory
// that can be reloaded over a side port while the core is held in LOAD.
module instr_fetch_unit #(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic [31:0]       Instruction,
  output logic [31:0]       pc,
  output logic [31:0]       branch_base,
  output logic [31:0]       opcplus4,
  input  logic [31:0]       Addr_result,
  input  logic [31:0]       Read_data_1,
  input  logic              Branch,
  input  logic              nBranch,
  input  logic              Jmp,
  input  logic              Jal,
  input  logic              Jr,
  input  logic              Zero,
  input  logic              stall,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              fetch_fault,
  output logic              loading
);

  typedef enum logic [1:0] {RUN, LOAD, RESTART} state_t;

  state_t      state, state_next;
  logic [31:0] imem [0:(2**ADDR_W)-1];
  logic [31:0] pcplus4;
  logic [31:0] pc_target;
  logic        branch_taken;
  logic        target_misaligned;
  logic        target_out_of_range;
  logic        run_update;
  logic        restart;
  logic        mem_we;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // A load request in RUN wins over stall; RESTART can chain straight back into LOAD.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (load_en) state_next = LOAD;
      LOAD:    if (!load_en) state_next = RESTART;
      RESTART: state_next = load_en ? LOAD : RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    loading     = (state == LOAD);
    restart     = (state == RESTART);
    run_update  = (state == RUN) && !load_en && !stall;
    mem_we      = (state == LOAD) && load_we;
    Instruction = (state == RUN) ? imem[pc[ADDR_W+1:2]] : 32'h0;
  end

  assign pcplus4     = pc + 32'd4;
  assign branch_base = pcplus4;

  always_comb begin
    branch_taken      = (Branch & Zero) | (nBranch & ~Zero);
    target_misaligned = 1'b0;
    pc_target         = pcplus4;
    if (Jr) begin
      pc_target         = Read_data_1 & ~32'h3;
      target_misaligned = |Read_data_1[1:0];
    end else if (Jmp | Jal) begin
      pc_target = {pcplus4[31:28], Instruction[25:0], 2'b00};
    end else if (branch_taken) begin
      pc_target         = Addr_result & ~32'h3;
      target_misaligned = |Addr_result[1:0];
    end
    target_out_of_range = |pc_target[31:ADDR_W+2];
  end

  // A faulting target is still loaded; the fault flag just records that it happened.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      pc          <= RESET_PC;
      opcplus4    <= 32'h0;
      fetch_fault <= 1'b0;
    end else if (run_update) begin
      pc <= pc_target;
      if (Jal) opcplus4 <= pcplus4;
      if (target_misaligned || target_out_of_range) fetch_fault <= 1'b1;
    end
  end

  // Memory contents survive reset so a partial download is not lost.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) imem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a behavioural model predicts
// each cycle's outputs, a monitor process compares them against the DUT.
module tb_instr_fetch_unit;

  localparam int ADDR_W    = 14;
  localparam int M_RUN     = 0;
  localparam int M_LOAD    = 1;
  localparam int M_RESTART = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [31:0]       Instruction, pc, branch_base, opcplus4;
  logic [31:0]       Addr_result, Read_data_1;
  logic              Branch, nBranch, Jmp, Jal, Jr, Zero, stall;
  logic              load_en, load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic              fetch_fault, loading;

  always #5 clock = ~clock;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .Instruction(Instruction), .pc(pc),
    .branch_base(branch_base), .opcplus4(opcplus4), .Addr_result(Addr_result),
    .Read_data_1(Read_data_1), .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp),
    .Jal(Jal), .Jr(Jr), .Zero(Zero), .stall(stall), .load_en(load_en),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .fetch_fault(fetch_fault), .loading(loading)
  );

  typedef struct packed {
    logic              reset, branch, nbranch, jmp, jal, jr, zero, stall, load_en, load_we;
    logic [31:0]       addr_result, rd1;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc, bb, op4, instr;
    logic        instr_chk, fault, loading;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  bit          sb_enable = 1'b0;

  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_op4 = 32'h0;
  bit          m_fault = 1'b0;
  int          m_mode = M_RUN;
  logic [31:0] m_mem [int];
  logic [31:0] prog [256];

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % (2 ** ADDR_W));
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Jump fields stay small so most jumps land inside the loaded program.
  function automatic logic [31:0] progWord();
    logic [31:0] w;
    w = $urandom;
    w[25:7] = '0;
    return w;
  endfunction

  function automatic logic [31:0] pickTarget();
    if ($urandom_range(0, 99) < 85) return 32'($urandom_range(0, 1023));
    return $urandom;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  // Drive one cycle, record the outputs expected before the edge, then step the model.
  task automatic applyStimulus(input stim_t s);
    exp_t        e;
    logic [31:0] nxt, instr;
    bit          mis, known;
    @(negedge clock);
    #1;
    reset = s.reset; Branch = s.branch; nBranch = s.nbranch; Jmp = s.jmp; Jal = s.jal;
    Jr = s.jr; Zero = s.zero; stall = s.stall; load_en = s.load_en; load_we = s.load_we;
    Addr_result = s.addr_result; Read_data_1 = s.rd1;
    load_addr = s.load_addr; load_data = s.load_data;

    known       = m_mem.exists(widx(m_pc));
    instr       = known ? m_mem[widx(m_pc)] : 32'h0;
    e.pc        = m_pc;
    e.bb        = m_pc + 32'd4;
    e.op4       = m_op4;
    e.fault     = m_fault;
    e.loading   = (m_mode == M_LOAD);
    e.instr_chk = (m_mode != M_RUN) || known;
    e.instr     = (m_mode == M_RUN) ? instr : 32'h0;
    if (sb_enable) sb.push_back(e);

    if (s.reset) begin
      m_pc = 32'h0; m_op4 = 32'h0; m_fault = 1'b0; m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (s.load_en) m_mode = M_LOAD;
      else if (!s.stall) begin
        mis = 1'b0;
        if (s.jr) begin
          nxt = s.rd1 - (s.rd1 % 4);
          mis = (s.rd1 % 4) != 0;
        end else if (s.jmp || s.jal) begin
          nxt = ((m_pc + 32'd4) & 32'hF000_0000) | ((instr % (2 ** 26)) * 4);
        end else if ((s.branch && s.zero) || (s.nbranch && !s.zero)) begin
          nxt = s.addr_result - (s.addr_result % 4);
          mis = (s.addr_result % 4) != 0;
        end else begin
          nxt = m_pc + 32'd4;
        end
        if (mis || (nxt / (2 ** (ADDR_W + 2))) != 0) m_fault = 1'b1;
        if (s.jal) m_op4 = m_pc + 32'd4;
        m_pc = nxt;
      end
    end else if (m_mode == M_LOAD) begin
      if (s.load_we) m_mem[int'(s.load_addr)] = s.load_data;
      if (!s.load_en) m_mode = M_RESTART;
    end else begin
      m_pc = 32'h0; m_op4 = 32'h0; m_fault = 1'b0;
      m_mode = s.load_en ? M_LOAD : M_RUN;
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("pc", pc, e.pc);
        checkOutput("branch_base", branch_base, e.bb);
        checkOutput("opcplus4", opcplus4, e.op4);
        checkOutput("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
        checkOutput("loading", {31'b0, loading}, {31'b0, e.loading});
        if (e.instr_chk) checkOutput("Instruction", Instruction, e.instr);
      end
    end
  end

  initial begin
    stim_t       s;
    logic [31:0] tgt;
    reset = 1'b1; Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0;
    stall = 0; load_en = 0; load_we = 0; Addr_result = '0; Read_data_1 = '0;
    load_addr = '0; load_data = '0;

    s = idle(); s.reset = 1'b1;
    applyStimulus(s);
    sb_enable = 1'b1;
    applyStimulus(s); settle();
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_opcplus4", opcplus4, 32'h0);
    checkOutput("reset_fault", {31'b0, fetch_fault}, 32'h0);

    // Program download.
    s = idle(); s.load_en = 1'b1;
    applyStimulus(s);
    for (int i = 0; i < 256; i++) begin
      prog[i] = (i == 16) ? 32'h0C00_0100 : progWord();
      s.load_we = 1'b1; s.load_addr = ADDR_W'(i); s.load_data = prog[i];
      applyStimulus(s);
      if (i == 0) begin
        settle();
        checkOutput("load_loading", {31'b0, loading}, 32'h1);
        checkOutput("load_instr_nop", Instruction, 32'h0);
      end
    end
    applyStimulus(idle());
    applyStimulus(idle()); settle();
    checkOutput("restart_loading", {31'b0, loading}, 32'h0);
    checkOutput("restart_instr_nop", Instruction, 32'h0);

    // Sequential fetch 0,4,8 then jr to 0x40 from 12.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(idle()); settle();
      checkOutput("seq_pc", pc, 32'(4 * k));
      checkOutput("seq_instr", Instruction, prog[k]);
    end
    s = idle(); s.jr = 1'b1; s.rd1 = 32'h40;
    applyStimulus(s); settle();
    checkOutput("seq_pc12", pc, 32'hC);
    s = idle(); s.jal = 1'b1;
    applyStimulus(s); settle();
    checkOutput("jal_instr", Instruction, 32'h0C00_0100);
    s = idle(); s.jr = 1'b1; s.jmp = 1'b1; s.rd1 = 32'h83;
    applyStimulus(s); settle();
    checkOutput("jal_pc", pc, 32'h400);
    checkOutput("jal_link", opcplus4, 32'h44);

    s = idle(); s.jr = 1'b1; s.rd1 = 32'h20;
    applyStimulus(s); settle();
    checkOutput("jr_prio_pc", pc, 32'h80);
    checkOutput("jr_fault", {31'b0, fetch_fault}, 32'h1);
    s = idle(); s.branch = 1'b1; s.zero = 1'b0; s.addr_result = 32'h100;
    applyStimulus(s); settle();
    s.zero = 1'b1;
    applyStimulus(s); settle();
    checkOutput("beq_not_taken", pc, 32'h24);
    s = idle(); s.stall = 1'b1; s.jal = 1'b1;
    applyStimulus(s); settle();
    checkOutput("beq_taken", pc, 32'h100);
    applyStimulus(s); settle();
    checkOutput("stall_pc", pc, 32'h100);
    checkOutput("stall_link", opcplus4, 32'h44);
    s.stall = 1'b0;
    applyStimulus(s); settle();
    s = idle(); s.jr = 1'b1; s.rd1 = 32'hFFFF_FFFC;
    applyStimulus(s); settle();
    tgt = {4'h0, prog[64][25:0], 2'b00};
    checkOutput("jal_release_pc", pc, tgt);
    checkOutput("jal_release_link", opcplus4, 32'h104);

    applyStimulus(idle()); settle();
    checkOutput("wrap_pc_top", pc, 32'hFFFF_FFFC);
    checkOutput("wrap_branch_base", branch_base, 32'h0);
    s = idle(); s.load_en = 1'b1;
    applyStimulus(s); settle();
    checkOutput("wrap_pc_zero", pc, 32'h0);

    // Reload one word and read it back after restart.
    s.load_we = 1'b1; s.load_addr = ADDR_W'(5); s.load_data = 32'hDEAD_BEEF;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(idle()); settle();
    checkOutput("restart_fault_held", {31'b0, fetch_fault}, 32'h1);
    s = idle(); s.jr = 1'b1; s.rd1 = 32'h14;
    applyStimulus(s); settle();
    checkOutput("restart_pc", pc, 32'h0);
    checkOutput("restart_fault_clr", {31'b0, fetch_fault}, 32'h0);
    s = idle(); s.load_en = 1'b1;
    applyStimulus(s); settle();
    checkOutput("readback", Instruction, 32'hDEAD_BEEF);

    // Reset in the middle of a download keeps what was already written.
    s.load_we = 1'b1; s.load_addr = ADDR_W'(6); s.load_data = 32'h1234_5678;
    applyStimulus(s);
    s = idle(); s.load_en = 1'b1; s.reset = 1'b1;
    applyStimulus(s);
    s = idle(); s.jr = 1'b1; s.rd1 = 32'h18;
    applyStimulus(s); settle();
    checkOutput("load_reset_mode", {31'b0, loading}, 32'h0);
    checkOutput("load_reset_pc", pc, 32'h0);
    applyStimulus(idle()); settle();
    checkOutput("load_reset_keep", Instruction, 32'h1234_5678);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.reset = ($urandom_range(0, 199) == 0);
      s.load_we = $urandom_range(0, 1);
      s.load_addr = ADDR_W'($urandom);
      s.load_data = $urandom;
      if (m_mode == M_RUN) begin
        s.load_en     = ($urandom_range(0, 99) < 3);
        s.stall       = ($urandom_range(0, 99) < 20);
        s.jr          = ($urandom_range(0, 99) < 15);
        s.jmp         = ($urandom_range(0, 99) < 10);
        s.jal         = ($urandom_range(0, 99) < 10);
        s.branch      = ($urandom_range(0, 99) < 25);
        s.nbranch     = ($urandom_range(0, 99) < 25);
        s.zero        = $urandom_range(0, 1);
        s.rd1         = pickTarget();
        s.addr_result = pickTarget();
        if (!m_mem.exists(widx(m_pc))) begin
          s.jmp = 1'b0; s.jal = 1'b0;
        end
      end else if (m_mode == M_LOAD) begin
        s.load_en   = ($urandom_range(0, 99) < 85);
        s.load_addr = ADDR_W'($urandom_range(0, 255));
        s.load_data = progWord();
      end else begin
        s.load_en = ($urandom_range(0, 99) < 10);
      end
      applyStimulus(s);
    end

    applyStimulus(idle());
    repeat (3) @(negedge clock);
    #5;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
